// File: rtl/time_keeper_if.sv
// Control and time bus between the timekeeping core and its user-interface / display consumers.
interface time_keeper_if;
  logic       set_mode;
  logic       sel;
  logic       inc;
  logic [5:0] current_hour;
  logic [5:0] current_min;
  logic [5:0] current_sec;
  logic       current_am_pm;
  logic       sec_tick;
  logic [1:0] set_field;

  modport master (
    output set_mode, sel, inc,
    input  current_hour, current_min, current_sec, current_am_pm, sec_tick, set_field
  );

  modport slave (
    input  set_mode, sel, inc,
    output current_hour, current_min, current_sec, current_am_pm, sec_tick, set_field
  );
endinterface

// File: rtl/time_keeper.sv
// 12-hour clock core: a prescaler derives 1 Hz advances from clk.
// A set mode freezes counting and edits one field at a time.
module time_keeper #(
  parameter int DIV = 50000000
) (
  input  logic          clk,
  input  logic          rst,
  time_keeper_if.slave  bus
);

  localparam int             PW     = $clog2(DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    FIELD_HOUR = 2'd0,
    FIELD_MIN  = 2'd1,
    FIELD_SEC  = 2'd2,
    FIELD_AMPM = 2'd3
  } field_e;

  logic [PW-1:0] pre_q,  pre_d;
  logic [5:0]    hour_q, hour_d;
  logic [5:0]    min_q,  min_d;
  logic [5:0]    sec_q,  sec_d;
  logic          pm_q,   pm_d;
  logic          tick_q, tick_d;
  field_e        field_q, field_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q   <= '0;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      pm_q    <= 1'b0;
      tick_q  <= 1'b0;
      field_q <= FIELD_HOUR;
    end else begin
      pre_q   <= pre_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      pm_q    <= pm_d;
      tick_q  <= tick_d;
      field_q <= field_d;
    end
  end

  // Set mode takes priority, so a freeze landing on a wrap cycle suppresses that advance.
  always_comb begin
    pre_d   = pre_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    pm_d    = pm_q;
    tick_d  = 1'b0;
    field_d = field_q;

    if (bus.set_mode) begin
      pre_d = '0;
      if (bus.inc) begin
        case (field_q)
          FIELD_HOUR: hour_d = (hour_q >= 6'd11) ? 6'd0 : hour_q + 6'd1;
          FIELD_MIN:  min_d  = (min_q  >= 6'd59) ? 6'd0 : min_q  + 6'd1;
          FIELD_SEC:  sec_d  = 6'd0;
          FIELD_AMPM: pm_d   = ~pm_q;
          default:    ;
        endcase
      end
      if (bus.sel) begin
        field_d = field_e'(field_q + 2'd1);
      end
    end else if (pre_q == PRE_MAX) begin
      pre_d  = '0;
      tick_d = 1'b1;
      if (sec_q >= 6'd59) begin
        sec_d = 6'd0;
        if (min_q >= 6'd59) begin
          min_d = 6'd0;
          if (hour_q >= 6'd11) begin
            hour_d = 6'd0;
            pm_d   = ~pm_q;
          end else begin
            hour_d = hour_q + 6'd1;
          end
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else begin
      pre_d = pre_q + PW'(1);
    end
  end

  assign bus.current_hour  = hour_q;
  assign bus.current_min   = min_q;
  assign bus.current_sec   = sec_q;
  assign bus.current_am_pm = pm_q;
  assign bus.sec_tick      = tick_q;
  assign bus.set_field     = field_q;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: directed scenarios plus randomized traffic, checked every cycle
// against a seconds-of-day model of the clock.
module tb_time_keeper;

  localparam int DIV = 4;
  localparam int DAY = 86400;
  localparam int HALF_DAY = 43200;

  logic clk;
  logic rst;

  time_keeper_if bus ();

  time_keeper #(.DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  // Reference: time as seconds since midnight, plus a count of cycles since the last advance.
  int mT;
  int mCycles;
  int mTick;
  int mField;

  function automatic int hourOf(input int t);
    return (t / 3600) % 12;
  endfunction

  function automatic int minOf(input int t);
    return (t / 60) % 60;
  endfunction

  function automatic int secOf(input int t);
    return t % 60;
  endfunction

  function automatic int pmOf(input int t);
    return (t >= HALF_DAY) ? 1 : 0;
  endfunction

  function automatic int editTime(input int t, input int field);
    int h, m, s, p;
    h = hourOf(t);
    m = minOf(t);
    s = secOf(t);
    p = pmOf(t);
    case (field)
      0:       h = (h + 1) % 12;
      1:       m = (m + 1) % 60;
      2:       s = 0;
      default: p = 1 - p;
    endcase
    return p * HALF_DAY + h * 3600 + m * 60 + s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mT = 0;
      mCycles = 0;
      mTick = 0;
      mField = 0;
    end else begin
      mTick = 0;
      if (bus.set_mode) begin
        mCycles = 0;
        if (bus.inc) mT = editTime(mT, mField);
        if (bus.sel) mField = (mField + 1) % 4;
      end else begin
        mCycles = mCycles + 1;
        if (mCycles == DIV) begin
          mCycles = 0;
          mT = (mT + 1) % DAY;
          mTick = 1;
        end
      end
    end
  end

  // Every-cycle comparison of the whole output bundle against the model.
  always @(negedge clk) begin
    checkCount = checkCount + 1;
    if (int'(bus.current_hour) == hourOf(mT) && int'(bus.current_min) == minOf(mT) &&
        int'(bus.current_sec) == secOf(mT) && int'(bus.current_am_pm) == pmOf(mT) &&
        int'(bus.sec_tick) == mTick && int'(bus.set_field) == mField) begin
      passCount = passCount + 1;
    end else begin
      $display("[TB] FAIL model-compare t=%0t actual=%0d:%0d:%0d pm=%0d tick=%0d field=%0d required=%0d:%0d:%0d pm=%0d tick=%0d field=%0d",
               $time, bus.current_hour, bus.current_min, bus.current_sec, bus.current_am_pm,
               bus.sec_tick, bus.set_field, hourOf(mT), minOf(mT), secOf(mT), pmOf(mT),
               mTick, mField);
    end
  end

  task automatic applyStimulus(input logic setMode, input logic selIn, input logic incIn);
    bus.set_mode = setMode;
    bus.sel      = selIn;
    bus.inc      = incIn;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int h, input int m, input int s,
                             input int pm, input int field);
    checkCount = checkCount + 1;
    if (int'(bus.current_hour) == h && int'(bus.current_min) == m &&
        int'(bus.current_sec) == s && int'(bus.current_am_pm) == pm &&
        int'(bus.set_field) == field) begin
      passCount = passCount + 1;
    end else begin
      $display("[TB] FAIL %s actual=%0d:%0d:%0d pm=%0d field=%0d required=%0d:%0d:%0d pm=%0d field=%0d",
               name, bus.current_hour, bus.current_min, bus.current_sec, bus.current_am_pm,
               bus.set_field, h, m, s, pm, field);
    end
  endtask

  task automatic checkBit(input string name, input int actual, input int required);
    checkCount = checkCount + 1;
    if (actual == required) begin
      passCount = passCount + 1;
    end else begin
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic incN(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b1);
  endtask

  task automatic selTo(input int f);
    for (int i = 0; i < 4 && mField != f; i++) applyStimulus(1'b1, 1'b1, 1'b0);
  endtask

  task automatic runNormal(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired before the scenario completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int tickSeen;
    rst = 1'b1;
    bus.set_mode = 1'b0;
    bus.sel = 1'b0;
    bus.inc = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset-state", 0, 0, 0, 0, 0);
    checkBit("reset-tick", int'(bus.sec_tick), 0);
    rst = 1'b0;

    $display("[TB] first ticks after reset");
    for (int c = 1; c <= 12; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (c % 4 == 0) begin
        checkBit("tick-on-wrap", int'(bus.sec_tick), 1);
        checkOutput("sec-after-tick", 0, 0, c / 4, 0, 0);
      end else if (c == 3) begin
        checkBit("no-early-tick", int'(bus.sec_tick), 0);
      end
    end

    $display("[TB] set 11:59:00 AM and roll into PM");
    applyStimulus(1'b1, 1'b1, 1'b0);
    incN(59);
    applyStimulus(1'b1, 1'b1, 1'b0);
    incN(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    incN(11);
    checkOutput("set-1159am", 11, 59, 0, 0, 0);
    runNormal(240);
    checkOutput("noon-rollover", 0, 0, 0, 1, 0);

    selTo(0);
    incN(11);
    selTo(1);
    incN(59);
    checkOutput("set-1159pm", 11, 59, 0, 1, 1);
    runNormal(240);
    checkOutput("midnight-rollover", 0, 0, 0, 0, 1);

    $display("[TB] freeze at 3:07:42");
    selTo(0);
    incN(3);
    selTo(1);
    incN(7);
    runNormal(170);
    checkOutput("reach-30742", 3, 7, 42, 0, 1);
    tickSeen = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (bus.sec_tick) tickSeen = 1;
    end
    checkBit("frozen-no-tick", tickSeen, 0);
    checkOutput("frozen-time", 3, 7, 42, 0, 1);
    runNormal(3);
    checkOutput("no-advance-before-div", 3, 7, 42, 0, 1);
    runNormal(1);
    checkBit("resume-tick", int'(bus.sec_tick), 1);
    checkOutput("resume-30743", 3, 7, 43, 0, 1);

    $display("[TB] hour wrap in set mode");
    selTo(0);
    incN(9);
    checkOutput("hour-to-zero", 0, 7, 43, 0, 0);
    incN(12);
    checkOutput("hour-12-incs", 0, 7, 43, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("sel-4-wrap", 0, 7, 43, 0, 0);

    $display("[TB] simultaneous sel and inc");
    selTo(1);
    incN(3);
    checkOutput("min-10", 0, 10, 43, 0, 1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("sel-inc-same-cycle", 0, 11, 43, 0, 2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("inc-ignored-normal", 0, 11, 43, 0, 2);

    $display("[TB] async reset at 9:30:15 PM");
    selTo(0);
    incN(9);
    selTo(1);
    incN(19);
    selTo(2);
    incN(1);
    selTo(3);
    incN(1);
    runNormal(60);
    checkOutput("reach-93015pm", 9, 30, 15, 1, 3);
    #3 rst = 1'b1;
    #1 checkOutput("async-reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] randomized traffic");
    bus.set_mode = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic sm;
      sm = bus.set_mode;
      if ($urandom_range(0, 19) == 0) sm = ~sm;
      if ($urandom_range(0, 599) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
      applyStimulus(sm, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end
    runNormal(8);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
Free-running 12-hour timekeeping core that produces the current time bus (hour 0-11, minute, second, AM/PM) consumed by the alarm comparator and display logic. It derives a 1 Hz advance from the system clock with a prescaler. It also provides a user set mode with field select and increment controls, using the same sel/inc convention as the alarm-setting path.

Parameters:
DIV, 50000000, system clock cycles per second; must be >= 2; prescaler width = clog2(DIV).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
set_mode  input  1  time-setting mode; counting frozen while high
sel  input  1  single-cycle pulse, advance edited field
inc  input  1  single-cycle pulse, increment edited field
current_hour  output  6  hour 0-11
current_min  output  6  minute 0-59
current_sec  output  6  second 0-59
current_am_pm  output  1  0 = AM, 1 = PM
sec_tick  output  1  one-cycle pulse on each normal-mode second advance
set_field  output  2  edited field: 0 hour, 1 minute, 2 second, 3 AM/PM

Behaviour:
- Reset (async, rst=1): all time outputs = 0, current_am_pm = 0, sec_tick = 0, set_field = 0, prescaler = 0. Takes effect immediately mid-operation. On release, counting restarts from 0:00:00 AM.
- All outputs are registered. No combinational path from input to output.
- Normal mode (set_mode=0):
  - Prescaler counts 0..DIV-1 and wraps to 0.
  - On the edge where the prescaler wraps, time advances 1 s. sec_tick is high for exactly one cycle, the same cycle the new time is visible.
  - sec 59->0 carries into min. min 59->0 carries into hour. hour 11->0 toggles am_pm.
  - Example: 11:59:59 AM -> 0:00:00 PM; 11:59:59 PM -> 0:00:00 AM.
  - First advance after reset or after leaving set mode occurs exactly DIV cycles later.
  - sel and inc are ignored.
- Set mode (set_mode=1):
  - Prescaler held at 0. No time advance. sec_tick = 0.
  - Each cycle with sel=1: set_field cycles 0->1->2->3->0.
  - Each cycle with inc=1 acts on the current set_field:
    - 0: hour 11->0 wrap, no am_pm toggle.
    - 1: min 59->0 wrap, no carry.
    - 2: sec cleared to 0.
    - 3: am_pm toggled.
  - sel and inc in the same cycle: inc applies to the field selected before the edge, then set_field advances.
  - inc held high for N cycles gives N increments. Debouncing and one-shot conversion are done upstream.
- set_field is kept across set_mode exit and re-entry. Only reset clears it.
- set_mode falling: the prescaler starts from 0 on the next cycle. Edited values are kept exactly.
- set_mode rising in the same cycle the prescaler would wrap: freeze wins, no advance, no sec_tick.
- Output values never leave their legal ranges (hour <= 11, min/sec <= 59).

Test Plan:
1. DIV=4, pulse rst then release -> 0:00:00 AM, set_field=0; sec_tick pulses on cycles 4, 8, 12 after release; current_sec = 1, 2, 3 on those cycles.
2. Set mode: sel once, inc 59 times -> min=59; sel once, inc -> sec=0; sel back to field 0, inc 11 times -> hour=11, AM; exit set mode. After 60 s (240 cycles) -> 0:00:00 PM with current_am_pm=1. After a further 12 h of ticks (wrap check) -> AM again.
3. Hold set_mode=1 for 100 cycles mid-count at 3:07:42 -> outputs unchanged, sec_tick never asserts. After release, the next advance is exactly 4 cycles later -> 3:07:43.
4. set_mode=1, inc 12 times on field 0 starting at hour 0 -> hour returns to 0, am_pm unchanged. sel 4 times -> set_field returns to 0.
5. set_field=1, min=10, sel and inc in the same cycle -> min=11, set_field=2. inc with set_mode=0 -> no change.
6. Assert rst asynchronously (between clk edges) at 9:30:15 PM during normal counting -> outputs read 0:00:00 AM before the next clk edge, and set_field=0.
